booth_sequencer: RTL and testbench

Sequencing controller for the radix-2 Booth signed multiplier datapath. It accepts a start request and latches the multiplicand and multiplier. It then runs exactly N add/subtract-and-shift steps on the A/Q/Q-1 working register and presents a registered 2N-bit product with a one-cycle done pulse. It also exports the per-step Booth decision and step count so the datapath and debug logic can be observed.

---
 rtl/booth_sequencer_if.sv | 24 ++
 rtl/booth_sequencer.sv | 111 +++++++++++
 tb/tb_booth_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/booth_sequencer_if.sv
// Operand/result bundle for the radix-2 Booth sequencer.
// The requester (master) drives start and the operands. The sequencer (slave) returns status and the product.
interface booth_sequencer_if #(
    parameter int N = 4
);
    logic                       start;
    logic [N-1:0]               Multiplicand;
    logic [N-1:0]               Multiplier_Q;
    logic                       busy;
    logic                       done;
    logic [1:0]                 op;
    logic [$clog2(N+1)-1:0]     step;
    logic [2*N-1:0]             Product;

    modport master (
        output start, Multiplicand, Multiplier_Q,
        input  busy, done, op, step, Product
    );

    modport slave (
        input  start, Multiplicand, Multiplier_Q,
        output busy, done, op, step, Product
    );
endinterface

// File: rtl/booth_sequencer.sv
// Radix-2 Booth signed multiplier sequencer: N add/subtract-and-shift steps on A/Q/Q-1.
// The sequencer registers a 2N-bit product and raises done for one cycle when the product is ready.
module booth_sequencer #(
    parameter int N = 4
) (
    input  logic               clk,
    input  logic               rst,
    booth_sequencer_if.slave   bus
);
    localparam int SW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    // A and M carry one guard bit so that M = -2^(N-1) cannot overflow.
    logic [N:0]        a_reg, a_next;
    logic [N:0]        m_reg, m_next;
    logic [N-1:0]      q_reg, q_next;
    logic              q1_reg, q1_next;
    logic [SW-1:0]     step_reg, step_next;
    logic [2*N-1:0]    product_reg, product_next;
    logic [N:0]        a_sum;
    logic [1:0]        op_comb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            m_reg       <= '0;
            q_reg       <= '0;
            q1_reg      <= 1'b0;
            step_reg    <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            m_reg       <= m_next;
            q_reg       <= q_next;
            q1_reg      <= q1_next;
            step_reg    <= step_next;
            product_reg <= product_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        m_next       = m_reg;
        q_next       = q_reg;
        q1_next      = q1_reg;
        step_next    = step_reg;
        product_next = product_reg;
        a_sum        = a_reg;
        op_comb      = 2'b00;

        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    m_next     = {bus.Multiplicand[N-1], bus.Multiplicand};
                    a_next     = '0;
                    q_next     = bus.Multiplier_Q;
                    q1_next    = 1'b0;
                    step_next  = SW'(N);
                    state_next = RUN;
                end
            end
            RUN: begin
                unique case ({q_reg[0], q1_reg})
                    2'b10: begin
                        op_comb = 2'b10;
                        a_sum   = a_reg - m_reg;
                    end
                    2'b01: begin
                        op_comb = 2'b01;
                        a_sum   = a_reg + m_reg;
                    end
                    default: begin
                        op_comb = 2'b00;
                        a_sum   = a_reg;
                    end
                endcase
                // Arithmetic right shift of {A', Q, Q-1}.
                a_next    = {a_sum[N], a_sum[N:1]};
                q_next    = {a_sum[0], q_reg[N-1:1]};
                q1_next   = q_reg[0];
                step_next = step_reg - SW'(1);
                if (step_reg == SW'(1)) begin
                    state_next   = DONE;
                    product_next = {a_next[N-1:0], q_next};
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_reg != IDLE);
    assign bus.done    = (state_reg == DONE);
    assign bus.op      = op_comb;
    assign bus.step    = step_reg;
    assign bus.Product = product_reg;

endmodule

// File: tb/tb_booth_sequencer.sv
// Directed scoreboard bench for booth_sequencer (N=4): products, op sequences, latency, abort and restart.
module tb_booth_sequencer;
    localparam int N  = 4;
    localparam int SW = $clog2(N + 1);

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [2*N-1:0] exp_q[$];

    booth_sequencer_if #(.N(N)) bus ();

    booth_sequencer #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int mv, input int qv);
        int p;
        logic [2*N-1:0] pe;
        p  = mv * qv;
        pe = p[2*N-1:0];
        exp_q.push_back(pe);
    endtask

    task automatic pop_check(input string tag);
        logic [2*N-1:0] pe;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            pe = exp_q.pop_front();
            check(tag, 32'(bus.Product), 32'(pe));
            $display("op result: Product=%0h expected=%0h", bus.Product, pe);
        end
    endtask

    // One full multiplication. pulse_at >= 0 raises start with other operands
    // during that RUN cycle, so it is sampled on the next edge and must be ignored.
    task automatic run_op(input int mv, input int qv, input int pulse_at);
        logic [N-1:0] mb, qb;
        logic [1:0]   bits, exp_op;
        int           cyc;
        mb = mv[N-1:0];
        qb = qv[N-1:0];
        @(negedge clk);
        bus.start        = 1'b1;
        bus.Multiplicand = mb;
        bus.Multiplier_Q = qb;
        push_exp(mv, qv);
        @(posedge clk); #1;
        bus.start        = 1'b0;
        bus.Multiplicand = N'($urandom);
        bus.Multiplier_Q = N'($urandom);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        check("step_after_accept", 32'(bus.step), 32'(N));
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < N + 4) begin
            if (cyc < N) begin
                bits   = {qb[cyc], (cyc == 0) ? 1'b0 : qb[cyc-1]};
                exp_op = (bits == 2'b11) ? 2'b00 : bits;
                check("op_step", 32'(bus.op), 32'(exp_op));
                check("busy_run", 32'(bus.busy), 32'd1);
            end
            if (cyc == pulse_at) begin
                bus.start        = 1'b1;
                bus.Multiplicand = 4'd5;
                bus.Multiplier_Q = 4'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        // Taking the accepting edge as edge 1, done follows edge N+1.
        check("done_latency", 32'(cyc), 32'(N));
        check("done_high", 32'(bus.done), 32'd1);
        check("busy_done", 32'(bus.busy), 32'd1);
        check("step_done", 32'(bus.step), 32'd0);
        check("op_done", 32'(bus.op), 32'd0);
        pop_check("product");
        @(posedge clk); #1;
        check("done_single_cycle", 32'(bus.done), 32'd0);
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("step_idle", 32'(bus.step), 32'd0);
    endtask

    initial begin
        int last_done;
        int n_done;
        int done_seen;
        logic [2*N-1:0] held;
        n_cmp = 0;
        n_err = 0;
        rst              = 1'b0;
        bus.start        = 1'b0;
        bus.Multiplicand = '0;
        bus.Multiplier_Q = '0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_op", 32'(bus.op), 32'd0);
        check("rst_step", 32'(bus.step), 32'd0);
        check("rst_product", 32'(bus.Product), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Idle with start low: Product holds.
        @(posedge clk); #1;
        check("idle_hold_busy", 32'(bus.busy), 32'd0);

        run_op(3, 5, -1);
        run_op(-8, -8, -1);
        run_op(-8, 7, -1);
        run_op(0, -1, -1);
        run_op(7, 0, -1);
        run_op(6, -3, 1);

        // Product must hold across idle cycles.
        held = bus.Product;
        repeat (3) @(posedge clk);
        #1;
        check("product_hold_idle", 32'(bus.Product), 32'(8'hEE));

        // Asynchronous abort during the second step; no done may follow.
        @(negedge clk);
        bus.start        = 1'b1;
        bus.Multiplicand = 4'd5;
        bus.Multiplier_Q = 4'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_op", 32'(bus.op), 32'd0);
        check("abort_step", 32'(bus.step), 32'd0);
        check("abort_product", 32'(bus.Product), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        done_seen = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        check("abort_product_held", 32'(held & 8'h00), 32'(bus.Product));

        run_op(2, 3, -1);

        // start held high: one result every N+2 cycles.
        @(negedge clk);
        bus.start        = 1'b1;
        bus.Multiplicand = 4'd1;
        bus.Multiplier_Q = 4'd1;
        for (int k = 0; k < 3; k++) push_exp(1, 1);
        n_done    = 0;
        last_done = -1;
        for (int c = 0; c < 40 && n_done < 3; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                if (last_done >= 0) check("restart_period", 32'(c - last_done), 32'(N + 2));
                pop_check("restart_product");
                last_done = c;
                n_done++;
            end
        end
        bus.start = 1'b0;
        check("restart_count", 32'(n_done), 32'd3);
        @(posedge clk); #1;
        check("restart_idle", 32'(bus.busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
